// File: rtl/fft_pkg.sv
// Shared constants, phase index tables and FSM state type for the
// sequential radix-2 FFT stage (fft_stage_seq and fft_tag_pipe).
package fft_pkg;

  localparam int CPX_W   = 64;             // one complex point
  localparam int N_PTS   = 32;             // points per frame
  localparam int N_MAC   = 4;              // butterfly units
  localparam int N_PHASE = 4;              // phases per frame
  localparam int FRAME_W = CPX_W * N_PTS;  // 2048
  localparam int RES_W   = 2 * CPX_W * N_MAC; // 512

  typedef logic [2:0] idx_t;

  // Within each group of 8 points, phase p pairs point I1[p] with I2[p].
  localparam idx_t I1 [N_PHASE] = '{3'd0, 3'd1, 3'd4, 3'd5};
  localparam idx_t I2 [N_PHASE] = '{3'd2, 3'd3, 3'd6, 3'd7};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit offset of point j of MAC group m inside a packed frame.
  function automatic int pt_base(input int m, input idx_t j);
    return (8 * m + int'(j)) * CPX_W;
  endfunction

endpackage

// File: rtl/fft_tag_pipe.sv
// Delay line for the phase tag (valid + 2-bit phase) that tracks the
// MAC result latency. LAT = 0 is a plain wire.
module fft_tag_pipe #(
  parameter int LAT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_vld,
  input  logic [1:0] in_ph,
  output logic       out_vld,
  output logic [1:0] out_ph
);

  if (LAT == 0) begin : g_pass
    assign out_vld = in_vld;
    assign out_ph  = in_ph;
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
  end else begin : g_pipe
    logic       vld_q [LAT];
    logic [1:0] ph_q  [LAT];

    // Shift the tag one stage per cycle; reset flushes in-flight tags so an
    // aborted frame never produces a late capture.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < LAT; i++) begin
          vld_q[i] <= 1'b0;
          ph_q[i]  <= 2'd0;
        end
      end else begin
        vld_q[0] <= in_vld;
        ph_q[0]  <= in_ph;
        for (int i = 1; i < LAT; i++) begin
          vld_q[i] <= vld_q[i-1];
          ph_q[i]  <= ph_q[i-1];
        end
      end
    end

    assign out_vld = vld_q[LAT-1];
    assign out_ph  = ph_q[LAT-1];
  end

endmodule

// File: rtl/fft_stage_seq.sv
// One radix-2 FFT stage over a 32-point frame, time-multiplexed over four
// external MAC butterflies in four phases.
// Optional feature macro: FFT_STAGE_SEQ_FRMCNT_EN adds a 16-bit frame_cnt
// output counting delivered frames.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE; out_valid is high only in
// DONE and out_data is held unchanged until out_ready accepts it.
module fft_stage_seq
  import fft_pkg::*;
#(
  parameter int MAC_LAT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FRAME_W-1:0]   in_data,
  output logic [FRAME_W-1:0]   mac_opnd,
  output logic [1:0]           mac_sel,
  input  logic [RES_W-1:0]     mac_res,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FRAME_W-1:0]   out_data,
  output logic                 busy
`ifdef FFT_STAGE_SEQ_FRMCNT_EN
  ,
  output logic [15:0]          frame_cnt
`endif
);

  // RUN ends once the last phase tag has passed through the delay line.
  localparam logic [2:0] LAST_CNT = 3'(N_PHASE - 1 + MAC_LAT);

  state_t     state;
  logic [2:0] cnt;       // index of the current RUN cycle
  logic       issue;     // a phase is being presented to the MACs
  logic       tag_vld;
  logic [1:0] tag_ph;

  assign in_ready = (state == IDLE);
  assign busy     = (state == RUN);
  assign issue    = (state == RUN) && (cnt < 3'(N_PHASE));
  assign mac_sel  = issue ? cnt[1:0] : 2'd0;

  // Frame control: accept in IDLE, step phases in RUN, hold result in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      mac_opnd  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mac_opnd <= in_data;
            cnt      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (cnt == LAST_CNT) begin
            cnt       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fft_tag_pipe #(
    .LAT (MAC_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (issue),
    .in_ph   (cnt[1:0]),
    .out_vld (tag_vld),
    .out_ph  (tag_ph)
  );

  // Scatter each MAC's two outputs to their frame points for the delayed phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
    end else if (tag_vld) begin
      for (int m = 0; m < N_MAC; m++) begin
        out_data[pt_base(m, I1[tag_ph]) +: CPX_W] <= mac_res[2*CPX_W*m +: CPX_W];
        out_data[pt_base(m, I2[tag_ph]) +: CPX_W] <= mac_res[2*CPX_W*m + CPX_W +: CPX_W];
      end
    end
  end

`ifdef FFT_STAGE_SEQ_FRMCNT_EN
  // Count delivered frames; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (out_valid && out_ready) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_stage_seq.sv
// Bench for fft_stage_seq: two instances (MAC_LAT 0 and 3), each with a
// MAC stub, a driver, and a monitor that checks against a reference stage.
module tb_fft_stage_seq;

  localparam int FW = 2048;
  localparam int RW = 512;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Compare whole frames; report the first differing point (point 0 if equal).
  task automatic chk_frame(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    int k;
    k = 0;
    for (int i = FW/64 - 1; i >= 0; i--)
      if (act[i*64 +: 64] !== exp[i*64 +: 64]) k = i;
    chk($sformatf("%s pt%0d", name, k), act[k*64 +: 64], exp[k*64 +: 64]);
  endtask

  // Reference stage: point j of each 8-group butterflies with j^2;
  // the lower-indexed member gets top+bot, the other top-bot.
  function automatic logic [FW-1:0] ref_stage(input logic [FW-1:0] d);
    logic [FW-1:0] r;
    logic [63:0] top, bot;
    int m, j;
    r = '0;
    for (int k = 0; k < 32; k++) begin
      m = k / 8;
      j = k % 8;
      top = d[(8*m + (j & 5)) * 64 +: 64];
      bot = d[(8*m + (j | 2)) * 64 +: 64];
      r[k*64 +: 64] = ((j & 2) != 0) ? top - bot : top + bot;
    end
    return r;
  endfunction

  // MAC stub: for phase p, MAC m outputs sum and difference of its pair.
  function automatic logic [RW-1:0] mac_stub(input logic [FW-1:0] op, input logic [1:0] p);
    logic [RW-1:0] r;
    logic [63:0] a, b;
    int t1 [4];
    int t2 [4];
    t1 = '{0, 1, 4, 5};
    t2 = '{2, 3, 6, 7};
    for (int m = 0; m < 4; m++) begin
      a = op[(8*m + t1[p]) * 64 +: 64];
      b = op[(8*m + t2[p]) * 64 +: 64];
      r[128*m +: 64]      = a + b;
      r[128*m + 64 +: 64] = a - b;
    end
    return r;
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] r;
    for (int k = 0; k < 32; k++) r[k*64 +: 64] = {$urandom, $urandom};
    return r;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int L = 3 * gi;

    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [FW-1:0] in_data = '0;
    logic [FW-1:0] mac_opnd;
    logic [1:0]    mac_sel;
    logic [RW-1:0] mac_res;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [FW-1:0] out_data;
    logic          busy;
`ifdef FFT_STAGE_SEQ_FRMCNT_EN
    logic [15:0]   frame_cnt;
    int            hs_cnt = 0;
`endif

    logic [RW-1:0] stub_now;
    logic [RW-1:0] stub_d [4];
    logic [FW-1:0] exp_q [$];
    int            acc_q [$];
    logic [FW-1:0] cur_opnd = '0;
    int            ordy_mode = 0;
    bit            rst_q = 1'b1;
    bit            fin = 1'b0;

    fft_stage_seq #(.MAC_LAT(L)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .mac_opnd  (mac_opnd),
      .mac_sel   (mac_sel),
      .mac_res   (mac_res),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
`ifdef FFT_STAGE_SEQ_FRMCNT_EN
      ,
      .frame_cnt (frame_cnt)
`endif
    );

    // MAC stub with L cycles of latency after mac_sel.
    assign stub_now = mac_stub(mac_opnd, mac_sel);
    always @(posedge clk) begin
      stub_d[0] <= stub_now;
      for (int i = 1; i < 4; i++) stub_d[i] <= stub_d[i-1];
    end
    assign mac_res = (L == 0) ? stub_now : stub_d[(L == 0) ? 0 : L - 1];

    always @(posedge clk) rst_q <= reset;

    // out_ready driver: 0 random, 1 always ready, 2 stalled.
    initial forever begin
      @(posedge clk); #1;
      case (ordy_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end

    task automatic send(input logic [FW-1:0] d, input bit hold, output int acc_t);
      in_data  = d;
      in_valid = 1'b1;
      acc_t    = -1;
      for (int w = 0; w < 100; w++) begin
        if (in_ready) begin
          acc_t = cyc;
          acc_q.push_back(cyc);
          exp_q.push_back(ref_stage(d));
          cur_opnd = d;
          @(posedge clk); #1;
          if (!hold) in_valid = 1'b0;
          return;
        end
        @(posedge clk); #1;
      end
      chk($sformatf("g%0d accept_timeout", gi), 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    endtask

    task automatic wait_drain();
      for (int w = 0; w < 300; w++) begin
        if (exp_q.size() == 0 && !out_valid) return;
        @(posedge clk); #1;
      end
      chk($sformatf("g%0d drain_timeout", gi), 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor / scoreboard.
    int            run_idx = 0;
    int            busy_len = 0;
    bit            prev_ov = 1'b0;
    bit            prev_hs = 1'b0;
    logic [FW-1:0] prev_od = '0;

    initial forever begin
      @(negedge clk);
      if (rst_q) begin
        chk($sformatf("g%0d reset_state", gi),
            64'({busy, out_valid, in_ready, mac_sel, |mac_opnd, |out_data}),
            64'(7'b0010000));
        run_idx = 0; busy_len = 0; prev_ov = 1'b0; prev_hs = 1'b0;
`ifdef FFT_STAGE_SEQ_FRMCNT_EN
        hs_cnt = 0;
`endif
      end else begin
        chk($sformatf("g%0d in_ready", gi), 64'(in_ready), 64'(!busy && !out_valid));
        if (busy) begin
          chk($sformatf("g%0d mac_sel_run%0d", gi, run_idx), 64'(mac_sel),
              64'((run_idx < 4) ? run_idx : 0));
          chk_frame($sformatf("g%0d mac_opnd", gi), mac_opnd, cur_opnd);
          run_idx++;
          busy_len++;
        end else begin
          chk($sformatf("g%0d mac_sel_idle", gi), 64'(mac_sel), 64'd0);
          run_idx = 0;
        end
        if (out_valid && !prev_ov) begin
          chk($sformatf("g%0d out_valid_expected", gi), 64'(acc_q.size() > 0), 64'd1);
          if (acc_q.size() > 0)
            chk($sformatf("g%0d latency", gi), 64'(cyc - acc_q.pop_front()), 64'(5 + L));
          chk($sformatf("g%0d busy_len", gi), 64'(busy_len), 64'(4 + L));
          busy_len = 0;
        end
        if (prev_hs)
          chk($sformatf("g%0d idle_after_hs", gi), 64'({out_valid, in_ready}), 64'(2'b01));
        if (out_valid && prev_ov)
          chk_frame($sformatf("g%0d hold_stable", gi), out_data, prev_od);
`ifdef FFT_STAGE_SEQ_FRMCNT_EN
        chk($sformatf("g%0d frame_cnt", gi), 64'(frame_cnt), 64'(hs_cnt[15:0]));
`endif
        prev_hs = out_valid && out_ready;
        if (prev_hs) begin
          chk($sformatf("g%0d hs_expected", gi), 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) chk_frame($sformatf("g%0d out_data", gi), out_data, exp_q.pop_front());
`ifdef FFT_STAGE_SEQ_FRMCNT_EN
          hs_cnt++;
`endif
        end
        prev_ov = out_valid;
        prev_od = out_data;
      end
    end

    // Stimulus.
    initial begin
      logic [FW-1:0] d;
      int t, prev_t;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Ramp frame: point k = k.
      ordy_mode = 1;
      for (int k = 0; k < 32; k++) d[k*64 +: 64] = 64'(k);
      send(d, 1'b0, t);
      wait_drain();

      // Random frames under random backpressure and idle gaps.
      ordy_mode = 0;
      for (int i = 0; i < 8; i++) begin
        send(rand_frame(), 1'b0, t);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      ordy_mode = 1;
      wait_drain();

      // Long stall: result must hold for 10 cycles, then drain.
      ordy_mode = 2;
      send(rand_frame(), 1'b0, t);
      for (int w = 0; w < 40 && !out_valid; w++) begin @(posedge clk); #1; end
      repeat (10) begin @(posedge clk); #1; end
      ordy_mode = 1;
      wait_drain();

      // Reset on the second RUN cycle: frame discarded, no out_valid.
      send(rand_frame(), 1'b0, t);
      @(posedge clk); #1;
      reset = 1'b1;
      exp_q.delete();
      acc_q.delete();
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b0;
      repeat (15) begin @(posedge clk); #1; end
      send(rand_frame(), 1'b0, t);
      wait_drain();

      // in_valid held high: back-to-back acceptance spacing.
      prev_t = 0;
      for (int i = 0; i < 5; i++) begin
        send(rand_frame(), 1'b1, t);
        if (i > 0) chk($sformatf("g%0d accept_spacing", gi), 64'(t - prev_t), 64'(6 + L));
        prev_t = t;
      end
      in_valid = 1'b0;
      wait_drain();
      repeat (3) begin @(posedge clk); #1; end
      fin = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 20000; t++) begin
      if (g_dut[0].fin && g_dut[1].fin) break;
      @(posedge clk);
    end
    if (!(g_dut[0].fin && g_dut[1].fin))
      chk("run_timeout", 64'({g_dut[0].fin, g_dut[1].fin}), 64'(2'b11));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
